// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of the single UART TX FIFO write port.
// Optional stall timeout with forced release is enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               fifo_full,
  output logic               fifo_wrreq,
  output logic [7:0]         fifo_data,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               timeout_err
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state, state_nxt;
  logic [2:0]         rr_ptr, rr_ptr_nxt, grant_nxt, scan_g, ptr_after;
  logic [3:0]         scan_sum;
  logic [N_REQ-1:0]   req_rot;
  logic               scan_hit, g_valid, g_last, xfer;
  logic [7:0]         g_data;

  // Bit k of req_rot is requester (rr_ptr + k) mod N_REQ, so the scan starts at rr_ptr.
  assign req_rot = N_REQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    scan_hit = 1'b0;
    scan_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!scan_hit && req_rot[k]) begin
        scan_hit = 1'b1;
        scan_sum = {1'b0, rr_ptr} + 4'(k);
      end
    end
    if (scan_sum >= 4'(N_REQ)) scan_sum = scan_sum - 4'(N_REQ);
  end
  assign scan_g = scan_sum[2:0];

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[8*i +: 8];
      end
    end
  end

  assign busy       = (state == LOCK);
  assign xfer       = busy & g_valid & ~fifo_full & ~rst;
  assign fifo_wrreq = xfer;
  assign fifo_data  = xfer ? g_data : 8'h00;
  assign ptr_after  = (grant_id == 3'(N_REQ-1)) ? 3'd0 : grant_id + 3'd1;

  for (genvar i = 0; i < N_REQ; i++) begin : g_ready
    assign req_ready[i] = xfer && (grant_id == 3'(i));
  end

`ifdef ARB_TIMEOUT_EN
  localparam int            SW         = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES-1);

  logic [SW-1:0] stall_cnt, stall_nxt;
  logic          to_nxt, stalled;

  // A full FIFO is not the grantee's fault, so it never advances the counter.
  assign stalled = busy & ~g_valid & ~fifo_full;
`endif

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_id;
`ifdef ARB_TIMEOUT_EN
    stall_nxt  = stall_cnt;
    to_nxt     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (scan_hit) begin
          state_nxt = LOCK;
          grant_nxt = scan_g;
`ifdef ARB_TIMEOUT_EN
          stall_nxt = '0;
`endif
        end
      end
      LOCK: begin
        if (xfer && g_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = ptr_after;
        end
`ifdef ARB_TIMEOUT_EN
        if (xfer) begin
          stall_nxt = '0;
        end else if (stalled) begin
          if (stall_cnt == STALL_LAST) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_after;
            to_nxt     = 1'b1;
            stall_nxt  = '0;
          end else begin
            stall_nxt = stall_cnt + SW'(1);
          end
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_id <= grant_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      stall_cnt   <= stall_nxt;
      timeout_err <= to_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-lane byte drivers, scoreboard of expected FIFO writes,
// negedge monitor. Timeout scenario runs when ARB_TIMEOUT_EN is defined, hold scenario otherwise.
module tb_uart_tx_arbiter;
  localparam int N = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           fifo_wrreq, busy, timeout_err;
  logic [7:0]     fifo_data;
  logic [2:0]     grant_id;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]  drv_q [N][$];   // {last, data} pending per requester
  logic [10:0] exp_q [$];      // {grant_id, data} expected FIFO writes in order
  logic [10:0] exp_e;
  logic [N-1:0] acc;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic send(input int lane, input logic [7:0] d, input bit last);
    drv_q[lane].push_back({last, d});
  endtask

  task automatic expect_wr(input int lane, input logic [7:0] d);
    exp_q.push_back({3'(lane), d});
  endtask

  task automatic wait_write(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = fifo_wrreq;
    end
    chk(name, seen, 1);
  endtask

  task automatic wait_busy(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = busy;
    end
    chk(name, seen, 1);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      done = !busy && exp_q.size() == 0 &&
             drv_q[0].size() == 0 && drv_q[1].size() == 0 && drv_q[2].size() == 0;
    end
    chk(name, done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < N; i++) drv_q[i].delete();
    #1;
    chk("rst_busy",    busy,        0);
    chk("rst_grant",   grant_id,    0);
    chk("rst_wrreq",   fifo_wrreq,  0);
    chk("rst_ready",   req_ready,   0);
    chk("rst_timeout", timeout_err, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Requester drivers: present queue head, pop after an edge that accepted it.
  initial begin
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        req_valid[i]       = drv_q[i].size() > 0;
        req_data[8*i +: 8] = req_valid[i] ? drv_q[i][0][7:0] : 8'h00;
        req_last[i]        = req_valid[i] ? drv_q[i][0][8] : 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on every FIFO write plus per-cycle invariants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_while_full", fifo_wrreq & fifo_full, 0);
      chk("ready_onehot", req_ready, fifo_wrreq ? (1 << grant_id) : 0);
      if (fifo_wrreq) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got id %0d data 0x%0h expected no write", grant_id, fifo_data);
        end else begin
          exp_e = exp_q.pop_front();
          chk("fifo_data", fifo_data, exp_e[7:0]);
          chk("write_grant", grant_id, exp_e[10:8]);
        end
      end else begin
        chk("data_idle_zero", fifo_data, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    do_reset();

    // 1: single requester, three-byte packet on consecutive cycles
    @(posedge clk); #2;
    send(0, 8'h41, 0); send(0, 8'h42, 0); send(0, 8'h43, 1);
    expect_wr(0, 8'h41); expect_wr(0, 8'h42); expect_wr(0, 8'h43);
    wait_busy("t1_grant");
    chk("t1_wr0", fifo_wrreq, 1);
    chk("t1_gid", grant_id, 0);
    @(negedge clk); chk("t1_wr1", fifo_wrreq, 1);
    @(negedge clk); chk("t1_wr2", fifo_wrreq, 1);
    @(negedge clk); chk("t1_busy_fall", busy, 0);
    wait_idle("t1_done");

    // 2: three contenders from rr_ptr=0
    do_reset();
    @(posedge clk); #2;
    send(0, 8'hA0, 0); send(0, 8'hA1, 1);
    send(1, 8'hB0, 0); send(1, 8'hB1, 1);
    send(2, 8'hC0, 0); send(2, 8'hC1, 1);
    expect_wr(0, 8'hA0); expect_wr(0, 8'hA1);
    expect_wr(1, 8'hB0); expect_wr(1, 8'hB1);
    expect_wr(2, 8'hC0); expect_wr(2, 8'hC1);
    wait_idle("t2_done");

    // 3: FIFO full mid-packet of req1, others waiting; rr_ptr then moves to 2
    @(posedge clk); #2;
    send(1, 8'h10, 0); send(1, 8'h11, 0); send(1, 8'h12, 0); send(1, 8'h13, 1);
    expect_wr(1, 8'h10); expect_wr(1, 8'h11); expect_wr(1, 8'h12); expect_wr(1, 8'h13);
    wait_write("t3_first");
    @(posedge clk); #2;
    fifo_full = 1'b1;
    send(2, 8'hC3, 1); send(0, 8'hA3, 1);
    expect_wr(2, 8'hC3); expect_wr(0, 8'hA3);
    repeat (5) begin
      @(negedge clk);
      chk("t3_no_wr",  fifo_wrreq, 0);
      chk("t3_ready",  req_ready,  0);
      chk("t3_busy",   busy,       1);
      chk("t3_gid",    grant_id,   1);
    end
    @(posedge clk); #2 fifo_full = 1'b0;
    wait_idle("t3_done");

    // 4: reset while req2 locked after its first byte; arbitration restarts at req0
    @(posedge clk); #2;
    send(2, 8'h20, 0); send(2, 8'h21, 0); send(2, 8'h22, 0); send(2, 8'h23, 1);
    expect_wr(2, 8'h20);
    wait_write("t4_first");
    do_reset();
    @(posedge clk); #2;
    send(1, 8'h51, 1); send(0, 8'h50, 1);
    expect_wr(0, 8'h50); expect_wr(1, 8'h51);
    wait_idle("t4_done");

    // 5/6: req1 sends one byte without last, then drops valid; req2 waits
    @(posedge clk); #2;
    send(1, 8'h61, 0);
    expect_wr(1, 8'h61);
    wait_write("t56_first");
    @(posedge clk); #2;
    send(2, 8'h62, 1);
`ifdef ARB_TIMEOUT_EN
    expect_wr(2, 8'h62);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk("t5_no_pulse", timeout_err, 0);
        chk("t5_held",     busy,        1);
      end else if (k == 9) begin
        chk("t5_pulse",    timeout_err, 1);
        chk("t5_released", busy,        0);
      end else begin
        chk("t5_pulse_end", timeout_err, 0);
        chk("t5_next_gid",  grant_id,    2);
        chk("t5_next_busy", busy,        1);
      end
    end
    wait_idle("t5_done");
`else
    repeat (110) begin
      @(negedge clk);
      chk("t6_held",    busy,        1);
      chk("t6_gid",     grant_id,    1);
      chk("t6_timeout", timeout_err, 0);
    end
    @(posedge clk); #2;
    send(1, 8'h63, 1);
    expect_wr(1, 8'h63); expect_wr(2, 8'h62);
    wait_idle("t6_done");
`endif

    chk("exp_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
